// File: rtl/fifo_pkg.sv
// Shared definitions for the inter-stage instruction FIFO and the blocks that produce
// or consume its elements.
package fifo_pkg;

  localparam int unsigned ELEM_SIZE_BITS_DEFAULT = 96;

  typedef logic [ELEM_SIZE_BITS_DEFAULT-1:0] fifo_elem_t;

  // Pointer advance with wrap at an arbitrary, not necessarily power-of-two, depth.
  function automatic int unsigned ring_next(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/skid_ring.sv
// Small ring-buffer store with head/tail pointers, occupancy count and a synchronous
// clear that wins over any write or read in the same cycle.
module skid_ring
  import fifo_pkg::*;
#(
  parameter int unsigned Width = ELEM_SIZE_BITS_DEFAULT,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned OccW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic [OccW-1:0]  occ_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             wr, rd;

  always_comb begin
    wr     = wr_en_i && !clr_i;
    rd     = rd_en_i && !clr_i && (occ_q != '0);
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (wr) begin
        mem_d[tail_q] = wr_data_i;
        tail_d        = PtrW'(ring_next(32'(tail_q), Depth));
      end
      if (rd) begin
        head_d = PtrW'(ring_next(32'(head_q), Depth));
      end
      unique case ({wr, rd})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  always_comb begin
    rd_data_o = mem_q[head_q];
    occ_o     = occ_q;
  end

  // The producer's credit scheme must never write into a full ring without a read.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(wr_en_i && !clr_i && !rd && (occ_q == OccW'(Depth))));

endmodule

// File: rtl/fifo_pop_adapter.sv
// Consumer-side adapter: turns the instruction queue's 1-cycle pop handshake into a
// valid/ready stream, using credit-based pops into a small skid buffer.
module fifo_pop_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned ELEM_SIZE_BITS = ELEM_SIZE_BITS_DEFAULT,
  parameter int unsigned BUF_DEPTH      = 2,
  parameter int unsigned STALL_W        = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ELEM_SIZE_BITS-1:0] q_out_data,
  input  logic                      q_pop_wait,
  output logic                      q_popping,
  output logic                      out_valid,
  output logic [ELEM_SIZE_BITS-1:0] out_data,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [$clog2(BUF_DEPTH):0] buffered,
  output logic [STALL_W-1:0]        empty_stalls
);

  localparam int unsigned OccW = $clog2(BUF_DEPTH) + 1;

  if (BUF_DEPTH < 2) begin : g_bad_depth
    $error("fifo_pop_adapter: BUF_DEPTH must be at least 2");
  end

  logic                      inflight_q, inflight_d;
  logic [STALL_W-1:0]        stalls_q, stalls_d;
  logic [OccW-1:0]           occ;
  logic [OccW:0]             credit_used;
  logic [ELEM_SIZE_BITS-1:0] head_data;
  logic                      deq;
  logic                      resp_wr;
  logic                      resp_refused;

  always_comb begin
    out_valid    = (occ != '0);
    out_data     = head_data;
    buffered     = occ;
    empty_stalls = stalls_q;
    deq          = out_valid && out_ready && !flush;
    // Slots already claimed once this cycle's dequeue is taken into account; the extra
    // bit keeps occ + inflight from overflowing at full occupancy.
    credit_used  = {1'b0, occ} + (OccW + 1)'(inflight_q) - (OccW + 1)'(deq);
    q_popping    = RESET && !flush && (credit_used < (OccW + 1)'(BUF_DEPTH));
  end

  always_comb begin
    // A response landing on a flush edge belongs to the discarded stream.
    resp_wr      = inflight_q && !q_pop_wait && !flush;
    resp_refused = inflight_q && q_pop_wait && !flush;
    inflight_d   = q_popping;
    stalls_d     = stalls_q;
    if (resp_refused && (stalls_q != '1)) begin
      stalls_d = stalls_q + STALL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      inflight_q <= 1'b0;
      stalls_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      stalls_q   <= stalls_d;
    end
  end

  skid_ring #(
    .Width (ELEM_SIZE_BITS),
    .Depth (BUF_DEPTH)
  ) u_skid_ring (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .clr_i     (flush),
    .wr_en_i   (resp_wr),
    .wr_data_i (q_out_data),
    .rd_en_i   (deq),
    .rd_data_o (head_data),
    .occ_o     (occ)
  );

endmodule

// File: tb/tb_fifo_pop_adapter.sv
// Bench for fifo_pop_adapter: a queue responder feeds the DUT, a scoreboard queue holds
// the elements expected at the output and a negedge monitor checks every transfer.
module tb_fifo_pop_adapter;

  localparam int unsigned EW    = 96;
  localparam int          Bound = 40;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [EW-1:0] q_out_data;
  logic          q_pop_wait;
  logic          q_popping;
  logic          out_valid;
  logic [EW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    buffered;
  logic [31:0]   empty_stalls;

  // Second instance with a 4-bit stall counter, fed by a permanently empty queue.
  logic          q_popping_s, out_valid_s;
  logic [EW-1:0] out_data_s;
  logic [1:0]    buffered_s;
  logic [3:0]    empty_stalls_s;
  logic [EW-1:0] q_out_data_s = '0;
  logic          q_pop_wait_s = 1'b1;
  logic          out_ready_s  = 1'b1;
  logic          flush_s      = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n;

  logic [EW:0]   src_q [$];  // MSB set marks a refused (empty-queue) response
  logic [EW-1:0] exp_q [$];
  int            pop_at  [int];
  int            xfer_at [int];

  logic          cur_pend = 1'b0, cur_wait = 1'b0;
  logic          nxt_pend = 1'b0, nxt_wait = 1'b0;
  logic [EW-1:0] nxt_data = '0;
  logic [EW:0]   tok;
  int            exp_stalls = 0;
  logic          s_pend = 1'b0;
  int            exp_s = 0;

  fifo_pop_adapter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .q_out_data   (q_out_data),
    .q_pop_wait   (q_pop_wait),
    .q_popping    (q_popping),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .flush        (flush),
    .buffered     (buffered),
    .empty_stalls (empty_stalls)
  );

  fifo_pop_adapter #(
    .STALL_W (4)
  ) dut_s (
    .CLK          (CLK),
    .RESET        (RESET),
    .q_out_data   (q_out_data_s),
    .q_pop_wait   (q_pop_wait_s),
    .q_popping    (q_popping_s),
    .out_valid    (out_valid_s),
    .out_data     (out_data_s),
    .out_ready    (out_ready_s),
    .flush        (flush_s),
    .buffered     (buffered_s),
    .empty_stalls (empty_stalls_s)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Queue responder: a pop seen in cycle k is answered during cycle k+1.
  always @(negedge CLK) begin
    if (RESET && cur_pend && cur_wait && !flush) exp_stalls++;
    nxt_pend = q_popping;
    nxt_wait = 1'b0;
    nxt_data = '0;
    if (q_popping) begin
      if (src_q.size() == 0) begin
        nxt_wait = 1'b1;
      end else begin
        tok = src_q.pop_front();
        if (tok[EW]) begin
          nxt_wait = 1'b1;
        end else begin
          nxt_data = tok[EW-1:0];
          pop_at[int'(tok[31:0])] = cyc;
        end
      end
    end
    if (RESET && s_pend) exp_s++;
    s_pend = q_popping_s;
  end

  always @(posedge CLK) begin
    cyc++;
    #1;
    cur_pend   = nxt_pend;
    cur_wait   = nxt_wait;
    q_out_data = nxt_data;
    q_pop_wait = nxt_wait;
  end

  // Output monitor / scoreboard.
  always @(negedge CLK) begin
    if (RESET && out_valid && out_ready && !flush) begin
      xfer_at[int'(out_data[31:0])] = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h, expected no transfer (cycle %0d)",
                 out_data, cyc);
      end else begin
        chk("stream_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; out_ready = 1'b1; flush = 1'b0; q_pop_wait = 1'b0; q_out_data = '0;
    #1 RESET = 1'b0;

    // Refused responses first, then 0xB0.
    repeat (5) src_q.push_back({1'b1, {EW{1'b0}}});
    src_q.push_back({1'b0, 96'hB0});
    exp_q.push_back(96'hB0);

    repeat (3) step();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_q_popping", q_popping, 0);
    chk("rst_buffered", buffered, 0);
    chk("rst_empty_stalls", empty_stalls, 0);
    chk("rst_empty_stalls_sat", empty_stalls_s, 0);

    step(); RESET = 1'b1; #1;
    chk("pop_after_reset", q_popping, 1);

    n = 0;
    while (!out_valid && n < Bound) begin step(); #1; n++; end
    chk("empty_latency", n, 7);
    chk("empty_data", out_data, 96'hB0);
    chk("empty_stalls_5", empty_stalls, 5);
    chk("sat_counting", empty_stalls_s, sat15(exp_s));
    repeat (3) step();
    #1;
    chk("empty_drain", exp_q.size(), 0);
    chk("stalls_model_1", empty_stalls, exp_stalls);

    // Streaming: four elements back-to-back.
    step();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back({1'b0, EW'(32'hA1 + i)});
      exp_q.push_back(EW'(32'hA1 + i));
    end
    repeat (8) step();
    #1;
    chk("stream_drain", exp_q.size(), 0);
    chk("stream_latency", xfer_at[32'hA1] - pop_at[32'hA1], 2);
    for (int i = 1; i < 4; i++) begin
      chk("stream_back_to_back", xfer_at[32'hA1 + i] - xfer_at[32'hA0 + i], 1);
    end

    // Backpressure.
    step(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_q.push_back({1'b0, EW'(32'hD1 + i)});
      exp_q.push_back(EW'(32'hD1 + i));
    end
    repeat (6) step();
    #1;
    chk("bp_buffered", buffered, 2);
    chk("bp_no_pop", q_popping, 0);
    chk("bp_head", out_data, 96'hD1);
    repeat (3) step();
    #1;
    chk("bp_head_stable", out_data, 96'hD1);
    step(); out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < Bound) begin step(); n++; end
    #1;
    chk("bp_drain", exp_q.size(), 0);
    chk("stalls_model_2", empty_stalls, exp_stalls);

    // Flush with two entries buffered, then with a response (0xC3) landing on the flush edge.
    step(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, EW'(32'hC1 + i)});
    exp_q.push_back(96'hC1);
    exp_q.push_back(96'hC4);
    exp_q.push_back(96'hC5);
    #1;
    n = 0;
    while (buffered != 2 && n < Bound) begin step(); #1; n++; end
    chk("fl_fill", buffered, 2);
    chk("fl_full_no_pop", q_popping, 0);
    chk("fl_head", out_data, 96'hC1);
    step(); out_ready = 1'b1; #1;
    chk("fl_deq_pop", q_popping, 1);
    step(); out_ready = 1'b0; flush = 1'b1; #1;
    chk("fl_occ_before", buffered, 1);
    chk("fl_no_pop", q_popping, 0);
    step(); flush = 1'b0; #1;
    chk("fl_cleared", buffered, 0);
    chk("fl_no_valid", out_valid, 0);
    step(); out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < Bound) begin step(); n++; end
    #1;
    chk("fl_drain", exp_q.size(), 0);
    repeat (2) step();
    #1;
    chk("stalls_model_3", empty_stalls, exp_stalls);

    // Saturating counter: well over 20 refused pops by now.
    chk("sat_value", empty_stalls_s, 15);
    chk("sat_model", empty_stalls_s, sat15(exp_s));
    repeat (5) step();
    #1;
    chk("sat_hold", empty_stalls_s, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
